boton_antirrebote: RTL and testbench

Front-end conditioner for a mechanical push-button. Synchronizes the raw asynchronous pin into the clock domain, rejects bounce with a stability counter and a four-state FSM, and emits a debounced level plus a one-cycle press pulse. The press pulse is the increment strobe that drives the `boton_i` input of the team's 8-bit counter.

---
 rtl/boton_antirrebote.sv | 107 ++++++++++
 tb/tb_boton_antirrebote.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/boton_antirrebote.sv
// rtl/boton_antirrebote.sv - two-flop synchronizer plus counter-qualified debounce FSM
// Emits a debounced level and a one-cycle strobe on each accepted press.
module boton_antirrebote #(
   parameter int STABLE_CYCLES = 100000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic reset_n_i,
   input  logic boton_i,
   output logic nivel_o,
   output logic pulso_o
);

   typedef enum logic [1:0] {
      BAJO        = 2'd0,
      VALIDA_ALTO = 2'd1,
      ALTO        = 2'd2,
      VALIDA_BAJO = 2'd3
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   estado_t          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nivel_q, nivel_d;
   logic             pulso_q, pulso_d;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         estado_q <= BAJO;
         cnt_q    <= '0;
         nivel_q  <= 1'b0;
         pulso_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         nivel_q  <= nivel_d;
         pulso_q  <= pulso_d;
      end
   end

   always_comb begin
      sync1_d  = boton_i;
      sync2_d  = sync1_q;
      estado_d = estado_q;
      cnt_d    = cnt_q;
      nivel_d  = nivel_q;
      pulso_d  = 1'b0;

      // Any sample that disagrees with the candidate level drops back to the stable state
      case (estado_q)
         BAJO: begin
            if (sync2_q) begin
               estado_d = VALIDA_ALTO;
               cnt_d    = CNT_UNO;
            end
         end
         VALIDA_ALTO: begin
            if (!sync2_q) begin
               estado_d = BAJO;
               cnt_d    = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = ALTO;
               cnt_d    = '0;
               nivel_d  = 1'b1;
               pulso_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_UNO;
            end
         end
         ALTO: begin
            if (!sync2_q) begin
               estado_d = VALIDA_BAJO;
               cnt_d    = CNT_UNO;
            end
         end
         VALIDA_BAJO: begin
            if (sync2_q) begin
               estado_d = ALTO;
               cnt_d    = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = BAJO;
               cnt_d    = '0;
               nivel_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_UNO;
            end
         end
         default: begin
            estado_d = BAJO;
            cnt_d    = '0;
            nivel_d  = 1'b0;
         end
      endcase
   end

   assign nivel_o = nivel_q;
   assign pulso_o = pulso_q;

endmodule

// File: tb/tb_boton_antirrebote.sv
// tb/tb_boton_antirrebote.sv - self-checking bench for boton_antirrebote
// Accepts a level once its last STABLE_CYCLES synchronized samples all disagree with the current level.
module tb_boton_antirrebote;

   localparam int S = 4;

   logic clk = 1'b0;
   logic reset_n_i;
   logic boton_i;
   logic nivel_o;
   logic pulso_o;

   boton_antirrebote #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .boton_i   (boton_i),
      .nivel_o   (nivel_o),
      .pulso_o   (pulso_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic boton;
      logic nivel;
      logic pulso;
   } vec_t;

   vec_t tabla[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   pulses = 0;
   logic prev_pulso = 1'b0;
   bit   hist[$];
   bit   m_lvl;
   bit   m_pul;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
      m_lvl = 1'b0;
      m_pul = 1'b0;
   endfunction

   // The level used at edge n is the pin sampled two edges earlier.
   function automatic void model_edge(input bit b);
      bit todos;
      todos = 1'b1;
      hist.push_back(b);
      for (int j = 0; j < S; j++)
         if (hist[hist.size() - 3 - j] == m_lvl) todos = 1'b0;
      void'(hist.pop_front());
      m_pul = 1'b0;
      if (todos) begin
         m_lvl = ~m_lvl;
         m_pul = m_lvl;
      end
   endfunction

   task automatic tick(input logic b);
      boton_i = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
      check("nivel", nivel_o, m_lvl);
      check("pulso", pulso_o, m_pul);
      if (prev_pulso) check("pulso_doble", pulso_o, 1'b0);
      prev_pulso = pulso_o;
      if (pulso_o) pulses++;
   endtask

   task automatic do_reset(input logic b);
      boton_i   = b;
      reset_n_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n_i  = 1'b1;
      prev_pulso = 1'b0;
      model_reset();
   endtask

   task automatic mid_reset(input string name);
      #2 reset_n_i = 1'b0;
      #1;
      check({name, "_nivel"}, nivel_o, 1'b0);
      check({name, "_pulso"}, pulso_o, 1'b0);
      #1 reset_n_i = 1'b1;
      prev_pulso = 1'b0;
      model_reset();
   endtask

   task automatic rep(input logic b, input logic l, input logic p, input int n);
      for (int i = 0; i < n; i++) tabla.push_back('{boton: b, nivel: l, pulso: p});
   endtask

   initial begin
      int   first;
      logic [7:0] contador;
      logic b;
      int   len;

      // idle, then a clean 20-cycle press: accepted on the 6th edge counting the first 1
      rep(0, 0, 0, 3);
      rep(1, 0, 0, 5); rep(1, 1, 1, 1); rep(1, 1, 0, 14);
      rep(0, 1, 0, 5); rep(0, 0, 0, 5);
      // bounce 1,0,1,1,0 then hold 1
      rep(1, 0, 0, 1); rep(0, 0, 0, 1); rep(1, 0, 0, 2); rep(0, 0, 0, 1);
      rep(1, 0, 0, 5); rep(1, 1, 1, 1); rep(1, 1, 0, 4);
      // release bounce of 3 samples keeps the level high
      rep(0, 1, 0, 3); rep(1, 1, 0, 6);
      rep(0, 1, 0, 5); rep(0, 0, 0, 3);
      // glitch of 3 samples is ignored
      rep(1, 0, 0, 3); rep(0, 0, 0, 6);
      // exactly S samples is the shortest accepted press
      rep(1, 0, 0, 4); rep(0, 0, 0, 1); rep(0, 1, 1, 1); rep(0, 1, 0, 3); rep(0, 0, 0, 3);

      reset_n_i = 1'b0;
      boton_i   = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("reset_nivel", nivel_o, 1'b0);
         check("reset_pulso", pulso_o, 1'b0);
      end
      reset_n_i = 1'b1;
      model_reset();
      pulses = 0;
      first  = -1;
      for (int i = 0; i < 12; i++) begin
         tick(1'b1);
         if (pulso_o && first < 0) first = i;
      end
      check("release_pulse_edge", first, 5);
      check("release_pulses", pulses, 1);
      check("release_nivel", nivel_o, 1'b1);

      do_reset(1'b0);
      foreach (tabla[i]) begin
         boton_i = tabla[i].boton;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("tabla[%0d].nivel", i), nivel_o, tabla[i].nivel);
         check($sformatf("tabla[%0d].pulso", i), pulso_o, tabla[i].pulso);
      end

      do_reset(1'b0);
      repeat (3) tick(1'b0);
      repeat (3) tick(1'b1);
      mid_reset("rst_valida");
      pulses = 0;
      repeat (10) tick(1'b1);
      check("rst_valida_pulses", pulses, 1);
      check("rst_valida_nivel", nivel_o, 1'b1);
      mid_reset("rst_alto");
      pulses = 0;
      repeat (10) tick(1'b1);
      check("rst_alto_pulses", pulses, 1);

      do_reset(1'b0);
      pulses = 0;
      for (int p = 0; p < 5; p++) begin
         tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
         repeat (8) tick(1'b1);
         repeat (8) tick(1'b0);
      end
      contador = pulses[7:0];
      check("contador", contador, 8'd5);

      do_reset(1'b0);
      repeat (300) begin
         b   = logic'($urandom_range(0, 1));
         len = $urandom_range(1, 2 * S);
         repeat (len) tick(b);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
